// File: rtl/multiplier_datapath_pkg.sv
// rtl/multiplier_datapath_pkg.sv - shared width, counter sizing and state encoding for the shift-add multiplier
package multiplier_datapath_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Step counter must hold the value WIDTH itself, not just WIDTH-1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/multiplier_datapath_mul_adder.sv
// rtl/multiplier_datapath_mul_adder.sv - combinational WIDTH-bit adder with carry-out forming {C,A}
module mul_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH:0]   o_sum
);

  assign o_sum = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/multiplier_datapath.sv
// rtl/multiplier_datapath.sv - shift-add multiplier datapath stepped by init/SR strobes from the controller
module multiplier_datapath
  import multiplier_datapath_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               init,
  input  logic               SR,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               q_lsb,
  output logic               busy,
  output logic               done
);

  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_acc;

  mul_adder #(.WIDTH(WIDTH)) u_adder (
    .i_a   (r_a),
    .i_b   (r_m),
    .o_sum (w_sum)
  );

  // {C,A} before the shift; the carry only lives within one step because the shift always clears it.
  assign w_acc = r_q[0] ? w_sum : {1'b0, r_a};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_cnt   <= '0;
    end else if (init) begin
      r_state <= ST_RUN;
      r_a     <= '0;
      r_q     <= multiplier;
      r_m     <= multiplicand;
      r_cnt   <= CW'(WIDTH);
    end else if (SR && (r_state == ST_RUN)) begin
      r_a   <= w_acc[WIDTH:1];
      r_q   <= {w_acc[0], r_q[WIDTH-1:1]};
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        r_state <= ST_DONE;
      end
    end
  end

  assign product = {r_a, r_q};
  assign q_lsb   = r_q[0];
  assign busy    = (r_state == ST_RUN);
  assign done    = (r_state == ST_DONE);

endmodule

// File: tb/tb_multiplier_datapath.sv
// tb/tb_multiplier_datapath.sv - self-checking bench for multiplier_datapath with an arithmetic reference model
module tb_multiplier_datapath;

  localparam int W = 8;

  logic           clock = 1'b0;
  logic           reset;
  logic           init;
  logic           SR;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic [2*W-1:0] product;
  logic           q_lsb;
  logic           busy;
  logic           done;

  int n_pass  = 0;
  int n_total = 0;

  multiplier_datapath #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .init         (init),
    .SR           (SR),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .q_lsb        (q_lsb),
    .busy         (busy),
    .done         (done)
  );

  always #5 clock = ~clock;

  // After k steps of shift-add: low k multiplier bits have been consumed into the
  // upper half, remaining multiplier bits sit shifted down in the lower half.
  function automatic logic [2*W-1:0] model(input int m, input int q, input int k);
    longint partial;
    partial = longint'(m) * longint'(q % (1 << k));
    return (2*W)'((partial << (W - k)) + longint'(q >> k));
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_init(input int m, input int q);
    multiplicand = W'(m);
    multiplier   = W'(q);
    init = 1'b1;
    tick();
    init = 1'b0;
    chk("init_busy", 32'(busy), 32'd1);
    chk("init_done", 32'(done), 32'd0);
    chk("init_product", 32'(product), 32'(q));
    chk("init_qlsb", 32'(q_lsb), 32'(q & 1));
  endtask

  task automatic steps(input int m, input int q, input int k0, input int n, input bit gaps);
    int k;
    logic [2*W-1:0] exp;
    k = k0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          tick();
          chk("gap_product", 32'(product), 32'(model(m, q, k)));
          chk("gap_done", 32'(done), 32'(k == W));
        end
      end
      SR = 1'b1;
      tick();
      SR = 1'b0;
      k++;
      exp = model(m, q, k);
      chk("step_product", 32'(product), 32'(exp));
      chk("step_qlsb", 32'(q_lsb), 32'(exp[0]));
      chk("step_busy", 32'(busy), 32'(k < W));
      chk("step_done", 32'(done), 32'(k == W));
    end
  endtask

  task automatic extra_sr(input int m, input int q, input int n);
    for (int i = 0; i < n; i++) begin
      SR = 1'b1;
      tick();
      SR = 1'b0;
      chk("extra_product", 32'(product), 32'(m * q));
      chk("extra_done", 32'(done), 32'd1);
      chk("extra_busy", 32'(busy), 32'd0);
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_product"}, 32'(product), 32'd0);
    chk({tag, "_qlsb"}, 32'(q_lsb), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int m;
    int q;
    reset = 1'b1;
    init = 1'b0;
    SR = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    tick();
    tick();
    reset = 1'b0;
    chk_cleared("reset");

    SR = 1'b1;
    tick();
    SR = 1'b0;
    chk_cleared("idle_sr");

    do_init(13, 11);
    steps(13, 11, 0, W, 1'b0);
    chk("p13x11", 32'(product), 32'h008F);

    do_init(255, 255);
    steps(255, 255, 0, W, 1'b1);
    chk("p255x255", 32'(product), 32'hFE01);

    do_init(0, 200);
    steps(0, 200, 0, W, 1'b0);
    extra_sr(0, 200, 3);
    do_init(200, 0);
    steps(200, 0, 0, W, 1'b0);
    extra_sr(200, 0, 3);

    do_init(7, 9);
    steps(7, 9, 0, 4, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_cleared("abort");
    repeat (2) begin
      SR = 1'b1;
      tick();
      SR = 1'b0;
      chk_cleared("abort_sr");
    end

    multiplicand = 8'd6;
    multiplier = 8'd5;
    init = 1'b1;
    SR = 1'b1;
    tick();
    init = 1'b0;
    SR = 1'b0;
    chk("coinc_product", 32'(product), 32'd5);
    chk("coinc_busy", 32'(busy), 32'd1);
    steps(6, 5, 0, W, 1'b0);
    chk("p6x5", 32'(product), 32'd30);

    do_init(100, 3);
    steps(100, 3, 0, 5, 1'b0);
    do_init(12, 12);
    steps(12, 12, 0, W, 1'b0);
    chk("p12x12", 32'(product), 32'd144);

    for (int t = 0; t < 12; t++) begin
      m = int'($urandom_range(0, 255));
      q = int'($urandom_range(0, 255));
      do_init(m, q);
      steps(m, q, 0, W, 1'b1);
      chk("rand_final", 32'(product), 32'(m * q));
      extra_sr(m, q, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
